spi_reg_ctrl: RTL
=================

// Module: spi_reg_ctrl
// PURPOSE
//  Register-bank controller between the SPI frame receiver and the PWM block.
//  - Buffers complete 16-bit SPI frames.
//  - Decodes write/read and address; drops invalid frames and counts them.
//  - Commits valid writes to the five PWM/output-enable registers.
//  - Optionally defers commits to PWM period boundaries.
// PARAMETERS
//  MAX_ADDR    4  highest valid register address; higher addresses are dropped
//  FIFO_DEPTH  2  frame buffer entries (power of 2, >=2)
//  DATA_W      8  register width; frame is {rw, addr[6:0], data[DATA_W-1:0]}
// PORTS
//  clk              in   1   single system clock
//  rst              in   1   asynchronous, active-high reset
//  frame_valid      in   1   receiver presents a complete frame
//  frame_data       in   16  [15]=rw (1=write), [14:8]=addr, [7:0]=data
//  frame_ready      out  1   frame accepted on clk edge when valid&ready
//  pwm_period_tick  in   1   1-cycle pulse at PWM period start
//  en_reg_out_7_0   out  8   addr 0
//  en_reg_out_15_8  out  8   addr 1
//  en_reg_pwm_7_0   out  8   addr 2
//  en_reg_pwm_15_8  out  8   addr 3
//  pwm_duty_cycle   out  8   addr 4
//  err_count        out  8   count of dropped frames (bad addr), saturates at 255
//  busy             out  1   FIFO non-empty or FSM not IDLE
// BEHAVIOUR
//  Reset (async, rst=1):
//   - All outputs 0; frame_ready=0 while rst is high.
//   - FIFO emptied; FSM to IDLE; any in-flight frame discarded.
//   - frame_ready=1 on the first cycle after rst deasserts.
//  FIFO:
//   - frame_ready = !full; push when valid&ready.
//   - Push and pop in the same cycle are both honoured.
//   - A full FIFO never drops: the receiver holds frame_valid.
//  FSM states: IDLE, DECODE, COMMIT.
//   - IDLE:   FIFO non-empty -> pop head into hold reg, go DECODE.
//   - DECODE: rw=1 and addr<=MAX_ADDR -> COMMIT.
//             rw=1 and addr>MAX_ADDR -> err_count+1 (saturating), go IDLE.
//             rw=0 (read)            -> silently dropped, not an error, go IDLE.
//   - COMMIT: write data to the addressed register, go IDLE.
//  Latency and throughput:
//   - Frame accepted at edge E0 -> register output changes at edge E3.
//   - Steady-state throughput: one frame per 3 cycles.
//  Register writes:
//   - Unaddressed registers hold their value.
//   - Writes are full-width; no read-modify-write.
// CONFIGURATION
//  Macro SHADOW_UPDATE_EN.
//  Defined:
//   - COMMIT writes a shadow register and sets a per-register dirty bit.
//   - On pwm_period_tick, every dirty live register loads its shadow value and
//     the dirty bit clears.
//   - COMMIT coinciding with tick: the tick copies the pre-edge shadow; the new
//     value stays in shadow with dirty set, applied on the next tick.
//   - busy also stays high while any dirty bit is set.
//  Undefined:
//   - No shadow registers; COMMIT writes the live register directly.
//   - pwm_period_tick is ignored.
// STRUCTURE
//  Package spi_reg_pkg:
//   - address constants ADDR_EN_OUT_7_0=0 .. ADDR_PWM_DUTY=4;
//   - frame field positions (RW_BIT=15, ADDR_MSB=14, ADDR_LSB=8);
//   - FSM state encoding.
//  Sub-module spi_frame_fifo: synchronous FIFO (FIFO_DEPTH x 16) with
//   full/empty flags and async active-high reset.
// TESTING
//  1. Write 0x8455 -> pwm_duty_cycle=0x55 at E3; other registers 0; err_count 0.
//  2. Back-to-back 0x80FF, 0x81AA, 0x8233 with frame_valid held high:
//     frame_ready drops when FIFO full; all three registers land in order;
//     no frame lost.
//  3. Frame 0x8712 (addr 7) -> no register change; err_count=1.
//     Frame 0x0412 (read)   -> no change; err_count unchanged.
//  4. 256 bad-address frames -> err_count saturates at 255.
//  5. rst pulse while FSM in COMMIT -> all outputs 0, busy=0;
//     the next frame after reset is processed normally.
//  6. (SHADOW_UPDATE_EN) Write 0x8480 -> pwm_duty_cycle stays 0 until the next
//     pwm_period_tick, then 0x80; COMMIT in the same cycle as tick -> applied
//     on the following tick.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: register addresses, frame field positions and FSM encoding for spi_reg_ctrl.
package spi_reg_pkg;
    localparam int FRAME_W         = 16;
    localparam int NUM_REGS        = 5;
    localparam int ADDR_EN_OUT_7_0 = 0;
    localparam int ADDR_EN_OUT_15_8 = 1;
    localparam int ADDR_EN_PWM_7_0 = 2;
    localparam int ADDR_EN_PWM_15_8 = 3;
    localparam int ADDR_PWM_DUTY   = 4;
    localparam int RW_BIT          = 15;
    localparam int ADDR_MSB        = 14;
    localparam int ADDR_LSB        = 8;
    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_COMMIT} state_e;
endpackage

// File: rtl/spi_frame_fifo.sv
// spi_frame_fifo: synchronous frame FIFO with full/empty flags; extra pointer bit
// distinguishes full from empty.
module spi_frame_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wptr_q, rptr_q;
    logic         do_push, do_pop;

    assign empty_o = wptr_q == rptr_q;
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= din_i;
    end
endmodule

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: buffers SPI frames, decodes writes and commits them to the PWM/enable registers.
// Define SHADOW_UPDATE_EN to defer commits to pwm_period_tick via shadow registers.
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int MAX_ADDR   = 4,
    parameter int FIFO_DEPTH = 2,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_valid,
    input  logic [15:0]       frame_data,
    output logic              frame_ready,
    input  logic              pwm_period_tick,
    output logic [DATA_W-1:0] en_reg_out_7_0,
    output logic [DATA_W-1:0] en_reg_out_15_8,
    output logic [DATA_W-1:0] en_reg_pwm_7_0,
    output logic [DATA_W-1:0] en_reg_pwm_15_8,
    output logic [DATA_W-1:0] pwm_duty_cycle,
    output logic [7:0]        err_count,
    output logic              busy
);
    state_e                           state_q, state_d;
    logic [FRAME_W-1:0]               hold_q, fifo_dout;
    logic [7:0]                       err_q;
    logic [NUM_REGS-1:0][DATA_W-1:0]  live_q;
    logic [NUM_REGS-1:0]              wsel;
    logic                             full, empty, pop, commit, err_inc, wr, addr_ok;
    logic [6:0]                       waddr;

    spi_frame_fifo #(.DEPTH(FIFO_DEPTH), .W(FRAME_W)) u_fifo (
        .clk(clk), .rst(rst),
        .push_i(frame_valid && frame_ready), .din_i(frame_data),
        .pop_i(pop), .dout_o(fifo_dout),
        .full_o(full), .empty_o(empty)
    );

    assign frame_ready = !full && !rst;
    assign wr          = hold_q[RW_BIT];
    assign waddr       = hold_q[ADDR_MSB:ADDR_LSB];
    assign addr_ok     = waddr <= 7'(MAX_ADDR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q == S_IDLE   ? (empty ? S_IDLE : S_DECODE) :
                  state_q == S_DECODE ? (wr && addr_ok ? S_COMMIT : S_IDLE) : S_IDLE;
    end

    always_comb begin
        pop     = state_q == S_IDLE && !empty;
        commit  = state_q == S_COMMIT;
        err_inc = state_q == S_DECODE && wr && !addr_ok;
    end

    always_comb begin
        wsel = '0;
        for (int i = 0; i < NUM_REGS; i++) wsel[i] = commit && waddr == 7'(i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
            err_q  <= '0;
        end else begin
            if (pop)     hold_q <= fifo_dout;
            if (err_inc) err_q  <= err_q + 8'(err_q != 8'hFF);
        end
    end

`ifdef SHADOW_UPDATE_EN
    logic [NUM_REGS-1:0][DATA_W-1:0] shadow_q;
    logic [NUM_REGS-1:0]             dirty_q;

    // A commit on a tick edge wins the dirty bit; the tick applies the older shadow value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_q   <= '0;
            shadow_q <= '0;
            dirty_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wsel[i]) shadow_q[i] <= hold_q[DATA_W-1:0];
                dirty_q[i] <= wsel[i] ? 1'b1 : (pwm_period_tick ? 1'b0 : dirty_q[i]);
                if (pwm_period_tick && dirty_q[i]) live_q[i] <= shadow_q[i];
            end
        end
    end

    assign busy = !empty || state_q != S_IDLE || |dirty_q;
`else
    logic unused_tick;
    assign unused_tick = pwm_period_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++)
                if (wsel[i]) live_q[i] <= hold_q[DATA_W-1:0];
        end
    end

    assign busy = !empty || state_q != S_IDLE;
`endif

    assign en_reg_out_7_0  = live_q[ADDR_EN_OUT_7_0];
    assign en_reg_out_15_8 = live_q[ADDR_EN_OUT_15_8];
    assign en_reg_pwm_7_0  = live_q[ADDR_EN_PWM_7_0];
    assign en_reg_pwm_15_8 = live_q[ADDR_EN_PWM_15_8];
    assign pwm_duty_cycle  = live_q[ADDR_PWM_DUTY];
    assign err_count       = err_q;
endmodule
